pwm_fade_sequencer: RTL
=======================

Name: pwm_fade_sequencer

Overview:
- Avalon-MM master that sequences the 8-bit PWM LED peripheral (slave regs: addr 0 enable[0], addr 1 duty[3:0], addr 2 period[31:0]; read returns duty with 1-cycle latency, no waitrequest).
- Programs the period, enables the PWM, then ramps duty 0→MAX→0 ("breathing") with a programmable dwell per step.
- Reads back every duty write to verify it.
- Sits between top-level control (keys/switches or HPS) and the PWM slave; it is the sole master on that slave.

Parameters:
- DUTY_W, 4, duty field width.
- MAX_DUTY, 15, ramp ceiling (must be ≤ 2**DUTY_W-1).
- DWELL_W, 24, dwell counter width.
- RAMPS_W, 8, ramp-count width.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle start pulse.
- stop, in, 1, single-cycle stop pulse.
- period_cfg, in, 32, PWM period; latched on accepted start.
- dwell_cfg, in, DWELL_W, clocks per duty step; latched on start; 0 is treated as 1.
- ramps_cfg, in, RAMPS_W, full up+down ramps to run; 0 means run forever; latched on start.
- m_address, out, 8, slave address.
- m_write, out, 1, write strobe.
- m_read, out, 1, read strobe.
- m_writedata, out, 32, write data.
- m_readdata, in, 32, read data, valid the cycle after m_read.
- busy, out, 1, high in every state except IDLE.
- duty_now, out, DUTY_W, last duty value written.
- done, out, 1, one-cycle pulse on return to IDLE.
- verify_err, out, 1, sticky readback mismatch; cleared by accepted start.

Behaviour:
- Reset (async):
  - All outputs 0, state INIT, direction up, counters 0.
  - Reset mid-sequence drops m_write/m_read immediately. No bus cycle completes.
- All bus outputs are registered. At most one of m_write/m_read is high per cycle. Each strobe lasts exactly 1 cycle. m_address and m_writedata are 0 when no strobe is active.
- FSM states and transitions:
  - INIT: write addr 0 data 0 (force PWM off, since the slave's enable is not reset) → IDLE.
  - IDLE: accepted start (start=1 and stop=0) → latch configs, clear verify_err, duty=0, dir=up, ramp_cnt=0 → WR_PER. start while busy is ignored.
  - WR_PER: write addr 2 data period_cfg_latched → WR_EN.
  - WR_EN: write addr 0 data 1 → WR_DUTY.
  - WR_DUTY: write addr 1 data {28'b0,duty}; duty_now←duty → RD_REQ.
  - RD_REQ: m_read=1, addr 1 → RD_WAIT.
  - RD_WAIT: compare m_readdata[DUTY_W-1:0] against duty; also require m_readdata[31:DUTY_W]==0. Mismatch sets verify_err; the sequence continues. Load dwell counter → DWELL.
  - DWELL: count down dwell_latched cycles, then step:
    - up: duty<MAX_DUTY → duty+1; at MAX_DUTY → dir=down, duty−1.
    - down: duty>0 → duty−1; at 0 → ramp_cnt+1 and dir=up. If ramps_cfg≠0 and ramp_cnt+1==ramps_cfg → WR_DIS; else duty+1.
    - After a step → WR_DUTY.
  - WR_DIS: write addr 0 data 0; pulse done → IDLE.
- Resulting ramp: one ramp = 0,1..15,14..0, i.e. 31 writes, with 0 shared between consecutive ramps.
- Per-step latency: 3 bus cycles plus dwell. First write occurs 1 cycle after start.
- stop:
  - Stop in any busy state other than INIT/WR_DIS: the current registered strobe cycle completes, next state is WR_DIS.
  - Stop arriving in RD_REQ: the RD_WAIT compare is skipped.
  - Stop in IDLE: ignored.
  - Stop and start in the same cycle: stop wins, start dropped.
- Arithmetic: duty never leaves [0, MAX_DUTY]. Dwell counter saturates, no wrap. ramp_cnt is RAMPS_W bits; in infinite mode it wraps freely.

Decomposition:
- Shared package pwm_pkg:
  - Register address constants PWM_ADDR_EN=0, PWM_ADDR_DUTY=1, PWM_ADDR_PERIOD=2.
  - Typedef fade_state_t (INIT, IDLE, WR_PER, WR_EN, WR_DUTY, RD_REQ, RD_WAIT, DWELL, WR_DIS).
  - DUTY_MAX default.
- One natural sub-module: avmm_single_master, which registers one write/read strobe per cycle and captures read data at a fixed 1-cycle latency. The FSM drives it with cmd/addr/data.

Test Plan:
- Reset release → first cycle m_write=1, addr 0, data 0; then IDLE with busy=0.
- start with period_cfg=1000, dwell_cfg=4, ramps_cfg=1 → writes addr2=1000, addr0=1, then duty 0..15..0. Expect 31 duty writes, each followed by a read at +1 and a 4-cycle dwell. Finishes with addr0=0, done pulse, verify_err=0.
- Same run with a slave model returning duty^1 on one read → verify_err=1 held until the next start; ramp still completes.
- ramps_cfg=0, stop pulsed during DWELL at duty 7 → next bus cycle is write addr0=0, done=1, busy=0, duty_now=7.
- start and stop in the same cycle from IDLE → no bus activity, busy stays 0. start during a run → ignored, no config change.
- dwell_cfg=0 → behaves as 1. Reset asserted mid-WR_DUTY → m_write=0 in the same cycle, then the INIT write follows on release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM LED peripheral and its fade sequencer.
package pwm_pkg;
    localparam int unsigned BUS_AW = 8;
    localparam int unsigned BUS_DW = 32;

    localparam logic [BUS_AW-1:0] PWM_ADDR_EN     = 8'd0;
    localparam logic [BUS_AW-1:0] PWM_ADDR_DUTY   = 8'd1;
    localparam logic [BUS_AW-1:0] PWM_ADDR_PERIOD = 8'd2;

    localparam int unsigned DUTY_MAX = 15;

    typedef enum logic [3:0] {
        INIT, IDLE, WR_PER, WR_EN, WR_DUTY, RD_REQ, RD_WAIT, DWELL, WR_DIS
    } fade_state_t;
endpackage

// File: rtl/avmm_single_master.sv
// Registers one Avalon-MM write or read strobe per cycle; read data arrives one cycle after m_read.
module avmm_single_master
    import pwm_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_write_c,
    input  logic              cmd_read_c,
    input  logic [BUS_AW-1:0] cmd_addr_c,
    input  logic [BUS_DW-1:0] cmd_data_c,
    output logic [BUS_AW-1:0] m_address,
    output logic              m_write,
    output logic              m_read,
    output logic [BUS_DW-1:0] m_writedata,
    input  logic [BUS_DW-1:0] m_readdata,
    output logic              rsp_valid,
    output logic [BUS_DW-1:0] rsp_data_c
);
    assign rsp_data_c = m_readdata;

    // Write takes precedence; address/data are zeroed on idle cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_write     <= 1'b0;
            m_read      <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
            rsp_valid   <= 1'b0;
        end else begin
            m_write     <= cmd_write_c;
            m_read      <= cmd_read_c && !cmd_write_c;
            m_address   <= (cmd_write_c || cmd_read_c) ? cmd_addr_c : '0;
            m_writedata <= cmd_write_c ? cmd_data_c : '0;
            rsp_valid   <= m_read;
        end
    end
endmodule

// File: rtl/pwm_fade_sequencer.sv
// Avalon-MM master that programs the PWM peripheral and breathes its duty 0..MAX..0 with readback checks.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W   = 4,
    parameter int unsigned MAX_DUTY = DUTY_MAX,
    parameter int unsigned DWELL_W  = 24,
    parameter int unsigned RAMPS_W  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [31:0]        period_cfg,
    input  logic [DWELL_W-1:0] dwell_cfg,
    input  logic [RAMPS_W-1:0] ramps_cfg,
    output logic [7:0]         m_address,
    output logic               m_write,
    output logic               m_read,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata,
    output logic               busy,
    output logic [DUTY_W-1:0]  duty_now,
    output logic               done,
    output logic               verify_err
);
    fade_state_t        state_q, state_nxt;
    logic [DUTY_W-1:0]  duty_q, duty_nxt;
    logic               dir_up_q, dir_up_nxt;
    logic [RAMPS_W-1:0] ramp_q, ramp_nxt, ramp_inc;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_nxt;
    logic [31:0]        period_q, period_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [RAMPS_W-1:0] ramps_q, ramps_nxt;
    logic               verr_nxt;

    logic               cmd_write_c, cmd_read_c, rsp_valid;
    logic [BUS_AW-1:0]  cmd_addr_c;
    logic [BUS_DW-1:0]  cmd_data_c, rsp_data_c;

    assign ramp_inc = ramp_q + RAMPS_W'(1);

    always_comb begin
        state_nxt     = state_q;
        duty_nxt      = duty_q;
        dir_up_nxt    = dir_up_q;
        ramp_nxt      = ramp_q;
        dwell_cnt_nxt = dwell_cnt_q;
        period_nxt    = period_q;
        dwell_nxt     = dwell_q;
        ramps_nxt     = ramps_q;
        verr_nxt      = verify_err;
        case (state_q)
            INIT:    state_nxt = IDLE;
            IDLE: begin
                if (start && !stop) begin
                    state_nxt  = WR_PER;
                    period_nxt = period_cfg;
                    dwell_nxt  = (dwell_cfg == '0) ? DWELL_W'(1) : dwell_cfg;
                    ramps_nxt  = ramps_cfg;
                    verr_nxt   = 1'b0;
                    duty_nxt   = '0;
                    dir_up_nxt = 1'b1;
                    ramp_nxt   = '0;
                end
            end
            WR_PER:  state_nxt = stop ? WR_DIS : WR_EN;
            WR_EN:   state_nxt = stop ? WR_DIS : WR_DUTY;
            WR_DUTY: state_nxt = stop ? WR_DIS : RD_REQ;
            RD_REQ:  state_nxt = stop ? WR_DIS : RD_WAIT;
            RD_WAIT: begin
                // Upper readback bits must be zero, so compare the full word.
                if (rsp_valid && (rsp_data_c != BUS_DW'(duty_q)))
                    verr_nxt = 1'b1;
                dwell_cnt_nxt = dwell_q;
                state_nxt     = stop ? WR_DIS : DWELL;
            end
            DWELL: begin
                if (stop) begin
                    state_nxt = WR_DIS;
                end else if (dwell_cnt_q > DWELL_W'(1)) begin
                    dwell_cnt_nxt = dwell_cnt_q - DWELL_W'(1);
                end else begin
                    dwell_cnt_nxt = '0;
                    state_nxt     = WR_DUTY;
                    if (dir_up_q) begin
                        if (duty_q < DUTY_W'(MAX_DUTY)) begin
                            duty_nxt = duty_q + DUTY_W'(1);
                        end else begin
                            dir_up_nxt = 1'b0;
                            duty_nxt   = duty_q - DUTY_W'(1);
                        end
                    end else if (duty_q != '0) begin
                        duty_nxt = duty_q - DUTY_W'(1);
                    end else begin
                        ramp_nxt   = ramp_inc;
                        dir_up_nxt = 1'b1;
                        if (ramps_q != '0 && ramp_inc == ramps_q)
                            state_nxt = WR_DIS;
                        else
                            duty_nxt = duty_q + DUTY_W'(1);
                    end
                end
            end
            WR_DIS:  state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // Each strobe is issued on the edge entering its state; the disable write lands with the return to IDLE.
    always_comb begin
        cmd_write_c = 1'b0;
        cmd_read_c  = 1'b0;
        cmd_addr_c  = '0;
        cmd_data_c  = '0;
        case (state_nxt)
            WR_PER:  begin cmd_write_c = 1'b1; cmd_addr_c = PWM_ADDR_PERIOD; cmd_data_c = period_nxt; end
            WR_EN:   begin cmd_write_c = 1'b1; cmd_addr_c = PWM_ADDR_EN; cmd_data_c = BUS_DW'(1); end
            WR_DUTY: begin cmd_write_c = 1'b1; cmd_addr_c = PWM_ADDR_DUTY; cmd_data_c = BUS_DW'(duty_nxt); end
            RD_REQ:  begin cmd_read_c = 1'b1; cmd_addr_c = PWM_ADDR_DUTY; end
            IDLE: begin
                if (state_q == INIT || state_q == WR_DIS) begin
                    cmd_write_c = 1'b1;
                    cmd_addr_c  = PWM_ADDR_EN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            duty_q      <= '0;
            dir_up_q    <= 1'b1;
            ramp_q      <= '0;
            dwell_cnt_q <= '0;
            period_q    <= '0;
            dwell_q     <= '0;
            ramps_q     <= '0;
            verify_err  <= 1'b0;
            duty_now    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            duty_q      <= duty_nxt;
            dir_up_q    <= dir_up_nxt;
            ramp_q      <= ramp_nxt;
            dwell_cnt_q <= dwell_cnt_nxt;
            period_q    <= period_nxt;
            dwell_q     <= dwell_nxt;
            ramps_q     <= ramps_nxt;
            verify_err  <= verr_nxt;
            busy        <= (state_nxt != IDLE);
            done        <= (state_q == WR_DIS);
            if (state_nxt == WR_DUTY)
                duty_now <= duty_nxt;
        end
    end

    avmm_single_master u_master (
        .clock       (clock),
        .reset       (reset),
        .cmd_write_c (cmd_write_c),
        .cmd_read_c  (cmd_read_c),
        .cmd_addr_c  (cmd_addr_c),
        .cmd_data_c  (cmd_data_c),
        .m_address   (m_address),
        .m_write     (m_write),
        .m_read      (m_read),
        .m_writedata (m_writedata),
        .m_readdata  (m_readdata),
        .rsp_valid   (rsp_valid),
        .rsp_data_c  (rsp_data_c)
    );
endmodule
